ias_fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the IAS execute datapath and feeds its opcode/address inputs.
- Fetches one memory word per PC value. Each word holds two instructions: left = bits [31:16], right = bits [15:0]; each instruction is {opcode[15:8], address[7:0]}.
- Issues the left instruction, parks the right one in an internal IBR (instruction buffer register), then issues the right one without a second memory access.
- Handles jumps, including jumps to the right half, and a HALT stop.

---
 rtl/ias_pkg.sv | 20 ++
 rtl/ias_fetch_unit_if.sv | 33 +++
 rtl/ias_ibr.sv | 37 +++
 rtl/ias_fetch_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ias_pkg.sv
// Shared types and field widths for the IAS instruction fetch unit.
// A memory word carries two {opcode, address} instructions, left half first.
package ias_pkg;

    localparam int OP_W    = 8;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = OP_W + ADDR_W;
    localparam int WORD_W  = 2 * INSTR_W;

    localparam logic [OP_W-1:0] OP_HALT = 8'hFF;
    localparam logic [OP_W-1:0] OP_NOP  = 8'h00;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE_L,
        ISSUE_R,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/ias_fetch_unit_if.sv
// Memory-fetch, issue and redirect signals between the fetch unit and its
// environment; master is the fetch unit, slave is memory plus execute stage.
interface ias_fetch_unit_if #(
    parameter int OP_W   = ias_pkg::OP_W,
    parameter int ADDR_W = ias_pkg::ADDR_W
);
    localparam int WORD_W = 2 * (OP_W + ADDR_W);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] address;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_addr;
    logic              jump_right;
    logic              halted;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output mem_req, mem_addr, issue_valid, opcode, address, halted, pc_out,
        input  mem_ack, mem_rdata, issue_ready, jump_valid, jump_addr, jump_right
    );

    modport slave (
        input  mem_req, mem_addr, issue_valid, opcode, address, halted, pc_out,
        output mem_ack, mem_rdata, issue_ready, jump_valid, jump_addr, jump_right
    );

endinterface

// File: rtl/ias_ibr.sv
// Instruction buffer register: parks the right-half instruction of a fetched
// word so it can issue without a second memory access.
module ias_ibr #(
    parameter int W = ias_pkg::INSTR_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         consume_i,
    input  logic         flush_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // A redirect always wins: whatever was parked belongs to the old stream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ias_fetch_unit.sv
// IAS fetch stage: one memory read per word, issues left then right half,
// handles redirects (optionally into the right half) and stops on HALT.
module ias_fetch_unit #(
    parameter int              OP_W    = ias_pkg::OP_W,
    parameter int              ADDR_W  = ias_pkg::ADDR_W,
    parameter logic [OP_W-1:0] HALT_OP = ias_pkg::OP_HALT
) (
    input logic              clk,
    input logic              reset,
    ias_fetch_unit_if.master bus
);
    import ias_pkg::*;

    localparam int IW = OP_W + ADDR_W;

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] address_q;
    logic [OP_W-1:0]   opcode_q;
    logic              mem_req_q;
    logic              issue_valid_q;
    logic              halted_q;
    logic              skip_left_q;
    logic              discard_q;

    logic          ibr_valid;
    logic [IW-1:0] ibr_data;
    logic [IW-1:0] word_l;
    logic [IW-1:0] word_r;
    logic          good_ack;
    logic          handshake;
    logic          is_halt;

    assign word_l    = bus.mem_rdata[2*IW-1:IW];
    assign word_r    = bus.mem_rdata[IW-1:0];
    assign good_ack  = mem_req_q && bus.mem_ack && !discard_q && !bus.jump_valid;
    assign handshake = issue_valid_q && bus.issue_ready && !bus.jump_valid;
    assign is_halt   = (opcode_q == HALT_OP);

    ias_ibr #(.W(IW)) u_ibr (
        .clk_i     (clk),
        .rst_ni    (reset),
        .load_i    (good_ack),
        .data_i    (word_r),
        .consume_i (handshake && (state_q == ISSUE_L) && !is_halt),
        .flush_i   (bus.jump_valid),
        .valid_o   (ibr_valid),
        .data_o    (ibr_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH;
            pc_q          <= '0;
            mem_addr_q    <= '0;
            opcode_q      <= '0;
            address_q     <= '0;
            mem_req_q     <= 1'b0;
            issue_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            skip_left_q   <= 1'b0;
            discard_q     <= 1'b0;
        end else if (bus.jump_valid) begin
            state_q       <= FETCH;
            pc_q          <= bus.jump_addr;
            skip_left_q   <= bus.jump_right;
            halted_q      <= 1'b0;
            issue_valid_q <= 1'b0;
            // An outstanding read cannot be withdrawn: keep asking for the old
            // word and throw it away when it arrives.
            mem_req_q     <= mem_req_q && !bus.mem_ack;
            discard_q     <= mem_req_q && !bus.mem_ack;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                    end else if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        discard_q <= 1'b0;
                        if (!discard_q) begin
                            pc_q          <= pc_q + 1'b1;
                            issue_valid_q <= 1'b1;
                            if (skip_left_q) begin
                                {opcode_q, address_q} <= word_r;
                                skip_left_q           <= 1'b0;
                                state_q               <= ISSUE_R;
                            end else begin
                                {opcode_q, address_q} <= word_l;
                                state_q               <= ISSUE_L;
                            end
                        end
                    end
                end
                ISSUE_L: begin
                    if (handshake) begin
                        if (is_halt) begin
                            issue_valid_q <= 1'b0;
                            halted_q      <= 1'b1;
                            state_q       <= HALT;
                        end else if (ibr_valid) begin
                            {opcode_q, address_q} <= ibr_data;
                            state_q               <= ISSUE_R;
                        end else begin
                            issue_valid_q <= 1'b0;
                            state_q       <= FETCH;
                        end
                    end
                end
                ISSUE_R: begin
                    if (handshake) begin
                        issue_valid_q <= 1'b0;
                        if (is_halt) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                HALT: begin
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.issue_valid = issue_valid_q && !bus.jump_valid;
    assign bus.opcode      = opcode_q;
    assign bus.address     = address_q;
    assign bus.halted      = halted_q;
    assign bus.pc_out      = pc_q;

endmodule
